// File: rtl/alu_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and ALU one-hot select for alu_ctrl_sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic add;
    logic inc;
    logic neg;
    logic sub;
  } alu_sel_t;

  localparam alu_sel_t ALU_NONE = alu_sel_t'(4'b0000);
  localparam alu_sel_t ALU_ADD  = alu_sel_t'(4'b1000);
  localparam alu_sel_t ALU_INC  = alu_sel_t'(4'b0100);
  localparam alu_sel_t ALU_NEG  = alu_sel_t'(4'b0010);
  localparam alu_sel_t ALU_SUB  = alu_sel_t'(4'b0001);

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: ALU one-hot select plus instruction-class flags.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output alu_sel_t         alu_sel,
  output logic             is_alu,
  output logic             is_mem,
  output logic             is_branch,
  output logic             is_illegal
);

  always_comb begin
    alu_sel    = ALU_NONE;
    is_alu     = 1'b0;
    is_mem     = 1'b0;
    is_branch  = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPC_W'(OP_NOP): ;
      OPC_W'(OP_ADD): begin
        alu_sel = ALU_ADD;
        is_alu  = 1'b1;
      end
      OPC_W'(OP_INC): begin
        alu_sel = ALU_INC;
        is_alu  = 1'b1;
      end
      OPC_W'(OP_NEG): begin
        alu_sel = ALU_NEG;
        is_alu  = 1'b1;
      end
      OPC_W'(OP_SUB): begin
        alu_sel = ALU_SUB;
        is_alu  = 1'b1;
      end
      // SVPC routes PC through the adder, so it shares the add select.
      OPC_W'(OP_SVPC): begin
        alu_sel = ALU_ADD;
        is_alu  = 1'b1;
      end
      OPC_W'(OP_LD), OPC_W'(OP_ST): is_mem = 1'b1;
      OPC_W'(OP_J), OPC_W'(OP_JM), OPC_W'(OP_BRZ), OPC_W'(OP_BRN): is_branch = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle DECODE/EXEC/MEM/WB control FSM driving the datapath ALU and memory strobes.
// Optional macro ILLEGAL_OP_TRAP_EN adds a trap output for illegal opcodes.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPC_W-1:0] opcode,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             add,
  output logic             inc,
  output logic             neg,
  output logic             sub,
  output logic             alu_cap,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_we,
  output logic             pc_load,
  output logic             done,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic             trap,
`endif
  output logic             flag_z,
  output logic             flag_n
);

  localparam int CNT_W = 4;

  state_t           r_state;
  logic [OPC_W-1:0] r_opcode;
  logic [CNT_W-1:0] r_cnt;
  alu_sel_t         r_sel;
  logic             r_instr_ready;
  logic             r_alu_cap;
  logic             r_mem_rd;
  logic             r_mem_wr;
  logic             r_reg_we;
  logic             r_pc_load;
  logic             r_done;
  logic             r_flag_z;
  logic             r_flag_n;
`ifdef ILLEGAL_OP_TRAP_EN
  logic             r_trap;
`endif

  alu_sel_t w_sel;
  logic     w_is_alu;
  logic     w_is_mem;
  logic     w_is_branch;
  logic     w_is_illegal;
  logic     w_is_ld;
  logic     w_is_svpc;
  logic     w_br_take;

  alu_op_decode #(
    .OPC_W(OPC_W)
  ) u_dec (
    .opcode    (r_opcode),
    .alu_sel   (w_sel),
    .is_alu    (w_is_alu),
    .is_mem    (w_is_mem),
    .is_branch (w_is_branch),
    .is_illegal(w_is_illegal)
  );

  assign w_is_ld   = (r_opcode == OPC_W'(OP_LD));
  assign w_is_svpc = (r_opcode == OPC_W'(OP_SVPC));

  always_comb begin
    w_br_take = w_is_branch;
    if (r_opcode == OPC_W'(OP_BRZ)) begin
      w_br_take = r_flag_z;
    end else if (r_opcode == OPC_W'(OP_BRN)) begin
      w_br_take = r_flag_n;
    end
  end

  // Outputs are registered, so each branch sets the strobes for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_opcode      <= '0;
      r_cnt         <= '0;
      r_sel         <= ALU_NONE;
      r_instr_ready <= 1'b1;
      r_alu_cap     <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_reg_we      <= 1'b0;
      r_pc_load     <= 1'b0;
      r_done        <= 1'b0;
      r_flag_z      <= 1'b0;
      r_flag_n      <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      r_trap        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef ILLEGAL_OP_TRAP_EN
          r_trap <= 1'b0;
`endif
          if (instr_valid && r_instr_ready) begin
            r_opcode      <= opcode;
            r_instr_ready <= 1'b0;
            r_state       <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (w_is_alu) begin
            r_sel     <= w_sel;
            r_alu_cap <= 1'b1;
            r_state   <= S_EXEC;
          end else if (w_is_mem) begin
            r_cnt    <= CNT_W'(MEM_LAT - 1);
            r_mem_rd <= w_is_ld;
            r_mem_wr <= !w_is_ld;
            // A single-cycle store retires in its only MEM cycle.
            r_done   <= !w_is_ld && (MEM_LAT == 1);
            r_state  <= S_MEM;
          end else if (w_is_illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
            r_trap        <= 1'b1;
            r_instr_ready <= 1'b1;
            r_state       <= S_IDLE;
`else
            r_done  <= 1'b1;
            r_state <= S_WB;
`endif
          end else begin
            r_pc_load <= w_br_take;
            r_done    <= 1'b1;
            r_state   <= S_WB;
          end
        end

        S_EXEC: begin
          r_sel     <= ALU_NONE;
          r_alu_cap <= 1'b0;
          if (!w_is_svpc) begin
            r_flag_z <= alu_z;
            r_flag_n <= alu_n;
          end
          r_reg_we <= 1'b1;
          r_done   <= 1'b1;
          r_state  <= S_WB;
        end

        S_MEM: begin
          if (r_cnt == '0) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (w_is_ld) begin
              r_reg_we <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= S_WB;
            end else begin
              r_done        <= 1'b0;
              r_instr_ready <= 1'b1;
              r_state       <= S_IDLE;
            end
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_done <= !w_is_ld && (r_cnt == CNT_W'(1));
          end
        end

        S_WB: begin
          r_reg_we      <= 1'b0;
          r_pc_load     <= 1'b0;
          r_done        <= 1'b0;
          r_instr_ready <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: begin
          r_instr_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign add         = r_sel.add;
  assign inc         = r_sel.inc;
  assign neg         = r_sel.neg;
  assign sub         = r_sel.sub;
  assign alu_cap     = r_alu_cap;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign reg_we      = r_reg_we;
  assign pc_load     = r_pc_load;
  assign done        = r_done;
  assign flag_z      = r_flag_z;
  assign flag_n      = r_flag_n;
`ifdef ILLEGAL_OP_TRAP_EN
  assign trap        = r_trap;
`endif

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed scoreboard bench for alu_ctrl_sequencer (MEM_LAT=2 main instance, MEM_LAT=1 store instance).
module tb_alu_ctrl_sequencer;

  localparam int ML = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic alu_z = 1'b0;
  logic alu_n = 1'b0;
  logic instr_ready, add, inc, neg, sub, alu_cap, mem_rd, mem_wr, reg_we, pc_load, done;
  logic flag_z, flag_n;

  logic v1 = 1'b0;
  logic [3:0] op1 = 4'h0;
  logic rdy1, add1, inc1, neg1, sub1, cap1, rd1, wr1, we1, pcl1, done1, fz1, fn1;
`ifdef ILLEGAL_OP_TRAP_EN
  logic trap, trap1;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         lat;
    int         trap_lat;
    int         n_rd;
    int         n_wr;
    int         n_cap;
    logic [3:0] sel;
    int         sel_cyc;
    int         n_we;
    int         n_pcl;
    logic       fz;
    logic       fn;
  } rec_t;

  rec_t sb[$];
  logic mz = 1'b0;
  logic mn = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_sequencer #(.OPC_W(4), .MEM_LAT(ML)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .alu_z(alu_z), .alu_n(alu_n),
    .add(add), .inc(inc), .neg(neg), .sub(sub), .alu_cap(alu_cap),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we), .pc_load(pc_load), .done(done),
`ifdef ILLEGAL_OP_TRAP_EN
    .trap(trap),
`endif
    .flag_z(flag_z), .flag_n(flag_n)
  );

  alu_ctrl_sequencer #(.OPC_W(4), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .instr_valid(v1), .instr_ready(rdy1),
    .opcode(op1), .alu_z(alu_z), .alu_n(alu_n),
    .add(add1), .inc(inc1), .neg(neg1), .sub(sub1), .alu_cap(cap1),
    .mem_rd(rd1), .mem_wr(wr1), .reg_we(we1), .pc_load(pcl1), .done(done1),
`ifdef ILLEGAL_OP_TRAP_EN
    .trap(trap1),
`endif
    .flag_z(fz1), .flag_n(fn1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic rec_t model(input logic [3:0] op, input logic z, input logic n);
    rec_t e = '{default: 0};
    e.lat = 2;
    e.fz  = mz;
    e.fn  = mn;
    case (op)
      4'h0: ;
      4'h3: begin e.lat = ML + 1; e.n_wr = ML; end
      4'h4, 4'h5, 4'h6, 4'h7, 4'hF: begin e.lat = 3; e.n_cap = 1; e.sel_cyc = 2; e.n_we = 1; end
      4'h8, 4'hA: e.n_pcl = 1;
      4'h9: e.n_pcl = int'(mz);
      4'hB: e.n_pcl = int'(mn);
      4'hE: begin e.lat = ML + 2; e.n_rd = ML; e.n_we = 1; end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        e.lat = 0;
        e.trap_lat = 2;
`endif
      end
    endcase
    case (op)
      4'h4, 4'hF: e.sel = 4'b1000;
      4'h5:       e.sel = 4'b0100;
      4'h6:       e.sel = 4'b0010;
      4'h7:       e.sel = 4'b0001;
      default:    e.sel = 4'b0000;
    endcase
    if (op inside {[4'h4:4'h7]}) begin
      e.fz = z;
      e.fn = n;
    end
    return e;
  endfunction

  // Issue one instruction from IDLE (called just after a falling edge) and score it.
  task automatic run_instr(input logic [3:0] op, input logic z, input logic n);
    rec_t e;
    rec_t o;
    string t;
    e = model(op, z, n);
    sb.push_back(e);
    mz = e.fz;
    mn = e.fn;
    o = '{default: 0};
    t = $sformatf("op%h", op);
    chk({t, "_ready_idle"}, instr_ready, 1);
    instr_valid = 1'b1;
    opcode = op;
    alu_z = z;
    alu_n = n;
    @(negedge clk);
    instr_valid = 1'b0;
    opcode = 4'($urandom);
    for (int k = 1; k <= 40; k++) begin
      chk({t, "_alu_onehot0"}, $onehot0({add, inc, neg, sub}), 1);
      chk({t, "_we_pcl_outside_done"}, (reg_we | pc_load) & ~done, 0);
      if ({add, inc, neg, sub} != 4'b0000) begin
        o.sel = o.sel | {add, inc, neg, sub};
        o.sel_cyc = k;
      end
      o.n_rd  += int'(mem_rd);
      o.n_wr  += int'(mem_wr);
      o.n_cap += int'(alu_cap);
      o.n_we  += int'(reg_we);
      o.n_pcl += int'(pc_load);
`ifdef ILLEGAL_OP_TRAP_EN
      if (trap) begin
        o.trap_lat = k;
        chk({t, "_trap_no_done"}, done, 0);
        break;
      end
`endif
      chk({t, "_ready_busy"}, instr_ready, 0);
      if (done) begin
        o.lat = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk({t, "_done_pulse"}, done, 0);
    o.fz = flag_z;
    o.fn = flag_n;
    e = sb.pop_front();
    chk({t, "_latency"}, o.lat, e.lat);
    chk({t, "_mem_rd_cycles"}, o.n_rd, e.n_rd);
    chk({t, "_mem_wr_cycles"}, o.n_wr, e.n_wr);
    chk({t, "_alu_cap_cycles"}, o.n_cap, e.n_cap);
    chk({t, "_alu_sel"}, o.sel, e.sel);
    chk({t, "_alu_sel_cycle"}, o.sel_cyc, e.sel_cyc);
    chk({t, "_reg_we"}, o.n_we, e.n_we);
    chk({t, "_pc_load"}, o.n_pcl, e.n_pcl);
    chk({t, "_flag_z"}, o.fz, e.fz);
    chk({t, "_flag_n"}, o.fn, e.fn);
`ifdef ILLEGAL_OP_TRAP_EN
    chk({t, "_trap_cycle"}, o.trap_lat, e.trap_lat);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", instr_ready, 1);
    chk("reset_outputs", {add, inc, neg, sub, alu_cap, mem_rd, mem_wr, reg_we, pc_load, done,
                          flag_z, flag_n}, 0);
    chk("reset_ready_dut1", rdy1, 1);
    @(negedge clk);

    run_instr(4'h7, 1'b1, 1'b0);  // SUB sets Z
    run_instr(4'h9, 1'b0, 1'b0);  // BRZ taken back-to-back
    run_instr(4'h6, 1'b0, 1'b1);  // NEG sets N, clears Z
    run_instr(4'hE, 1'b1, 1'b0);  // LD must not touch flags
    run_instr(4'hB, 1'b0, 1'b0);  // BRN taken
    run_instr(4'h9, 1'b1, 1'b1);  // BRZ not taken
    run_instr(4'h3, 1'b0, 1'b0);
    run_instr(4'h8, 1'b0, 1'b0);
    run_instr(4'hA, 1'b0, 1'b0);
    run_instr(4'hF, 1'b1, 1'b0);  // SVPC leaves flags alone
    run_instr(4'h0, 1'b1, 1'b1);
    run_instr(4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_instr(4'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_instr(4'h4, 1'b1, 1'b1);

    // Reset during EXEC of ADD: aborts with no done, flags cleared.
    chk("rst_pre_ready", instr_ready, 1);
    instr_valid = 1'b1;
    opcode = 4'h4;
    alu_z = 1'b0;
    alu_n = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_exec_add", add, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", instr_ready, 1);
    chk("rst_mid_strobes", {add, inc, neg, sub, alu_cap, mem_rd, mem_wr, reg_we, pc_load, done}, 0);
    chk("rst_mid_flags", {flag_z, flag_n}, 0);
    @(negedge clk);
    rst = 1'b0;
    mz = 1'b0;
    mn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
      chk("rst_idle_ready", instr_ready, 1);
    end
    chk("scoreboard_drained", sb.size(), 0);

    // MEM_LAT=1 store with ADD held on the bus: ADD waits until the cycle after done.
    chk("st1_ready", rdy1, 1);
    v1 = 1'b1;
    op1 = 4'h3;
    @(negedge clk);
    op1 = 4'h4;
    chk("st1_decode_ready", rdy1, 0);
    chk("st1_decode_wr", wr1, 0);
    @(negedge clk);
    chk("st1_mem_wr", wr1, 1);
    chk("st1_mem_done", done1, 1);
    chk("st1_mem_ready", rdy1, 0);
    chk("st1_mem_add", add1, 0);
    @(negedge clk);
    chk("st1_idle_wr", wr1, 0);
    chk("st1_idle_ready", rdy1, 1);
    chk("st1_idle_done", done1, 0);
    @(negedge clk);
    v1 = 1'b0;
    chk("add1_decode_ready", rdy1, 0);
    chk("add1_decode_add", add1, 0);
    @(negedge clk);
    chk("add1_exec_add", add1, 1);
    chk("add1_exec_cap", cap1, 1);
    @(negedge clk);
    chk("add1_wb_done", done1, 1);
    chk("add1_wb_we", we1, 1);
    chk("add1_wb_add", add1, 0);
    @(negedge clk);
    chk("add1_after_ready", rdy1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
